// File: rtl/branch_resolve_unit.sv
// Branch condition resolver with a PC-indexed table of 2-bit saturating predictors.
// Optional BRANCH_STATS_EN adds saturating branch and mispredict counters.
module branch_resolve_unit #(
   parameter int DW        = 32,
   parameter int PC_W      = 32,
   parameter int BHT_DEPTH = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] pred_pc,
   output logic            pred_taken,
   input  logic            res_valid,
   input  logic [PC_W-1:0] res_pc,
   input  logic [5:0]      res_op,
   input  logic [4:0]      res_rt,
   input  logic [DW-1:0]   res_a,
   input  logic [DW-1:0]   res_b,
   input  logic            res_pred_taken,
   input  logic            stall,
   input  logic            flush,
   output logic            br_valid,
   output logic            br_taken,
   output logic            br_mispredict,
   output logic            br_link,
   output logic            br_illegal
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [IDX_W-1:0]       pred_idx;
   logic [IDX_W-1:0]       res_idx;
   logic [2*BHT_DEPTH-1:0] bht_flat;
   logic [1:0]             res_ctr;
   logic [1:0]             res_ctr_next;
   logic                   a_neg;
   logic                   a_zero;
   logic                   cond_taken;
   logic                   cond_legal;
   logic                   cond_link;
   logic                   accepted;
   logic                   do_update;
   logic                   unused_pc_bits;

   assign pred_idx = pred_pc[IDX_W+1:2];
   assign res_idx  = res_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                             res_pc[PC_W-1:IDX_W+2], res_pc[1:0]};

   assign a_neg  = res_a[DW-1];
   assign a_zero = (res_a == '0);

   always_comb begin
      cond_taken = 1'b0;
      cond_legal = 1'b1;
      cond_link  = 1'b0;
      case (res_op)
         6'b000100: cond_taken = (res_a == res_b);
         6'b000101: cond_taken = (res_a != res_b);
         6'b000110: cond_taken = a_neg || a_zero;
         6'b000111: cond_taken = !a_neg && !a_zero;
         6'b000001: begin
            case (res_rt)
               5'b00000: cond_taken = a_neg;
               5'b00001: cond_taken = !a_neg;
               5'b10000: begin
                  cond_taken = a_neg;
                  cond_link  = 1'b1;
               end
               5'b10001: begin
                  cond_taken = !a_neg;
                  cond_link  = 1'b1;
               end
               default: cond_legal = 1'b0;
            endcase
         end
         default: cond_legal = 1'b0;
      endcase
   end

   assign accepted  = res_valid && !stall && !flush;
   assign do_update = accepted && cond_legal;

   // Outcome registers: flush clears, stall freezes, otherwise track ID.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         br_valid      <= 1'b0;
         br_taken      <= 1'b0;
         br_mispredict <= 1'b0;
         br_link       <= 1'b0;
         br_illegal    <= 1'b0;
      end else if (flush) begin
         br_valid      <= 1'b0;
         br_taken      <= 1'b0;
         br_mispredict <= 1'b0;
         br_link       <= 1'b0;
         br_illegal    <= 1'b0;
      end else if (!stall) begin
         br_valid      <= res_valid;
         br_taken      <= res_valid && cond_taken;
         br_mispredict <= res_valid && cond_legal && (cond_taken != res_pred_taken);
         br_link       <= res_valid && cond_link;
         br_illegal    <= res_valid && !cond_legal;
      end
   end

   assign res_ctr = bht_flat[{res_idx, 1'b0} +: 2];

   always_comb begin
      res_ctr_next = res_ctr;
      if (cond_taken) begin
         if (res_ctr != 2'b11) res_ctr_next = res_ctr + 2'b01;
      end else begin
         if (res_ctr != 2'b00) res_ctr_next = res_ctr - 2'b01;
      end
   end

   // Counters are flops so every entry can be reset to weak-not-taken at once.
   generate
      for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
         logic [1:0] ctr_reg;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               ctr_reg <= 2'b01;
            else if (do_update && (res_idx == IDX_W'(gi)))
               ctr_reg <= res_ctr_next;
         end
         assign bht_flat[2*gi +: 2] = ctr_reg;
      end
   endgenerate

   // No bypass: a same-cycle update is seen only after the edge.
   assign pred_taken = bht_flat[{pred_idx, 1'b1}];

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (do_update) begin
         if (stat_branches != 32'hFFFF_FFFF)
            stat_branches <= stat_branches + 32'd1;
         if ((cond_taken != res_pred_taken) && (stat_mispredicts != 32'hFFFF_FFFF))
            stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

endmodule
